dflow_gen_sequencer: RTL and testbench

DFLOW_GEN_SEQUENCER -- requirements
Module: dflow_gen_sequencer

---
 rtl/dflow_gen_sequencer_pkg.sv | 30 +++
 rtl/dflow_gen_sequencer_phase_timer.sv | 29 ++
 rtl/dflow_gen_sequencer.sv | 168 ++++++++++++++++
 tb/tb_dflow_gen_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dflow_gen_sequencer_pkg.sv
// Shared types and defaults for the QDR store/replay sequencer.
package dflow_gen_sequencer_pkg;

    localparam int unsigned DFLOW_QDR_ADDR_WIDTH = 19;
    localparam int unsigned DFLOW_LOOP_WIDTH     = 16;
    localparam int unsigned DFLOW_TIMEOUT_WIDTH  = 32;
    localparam int unsigned DFLOW_SW_RST_CYCLES  = 16;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_WAIT_CAL   = 4'd1,
        ST_SWRST      = 4'd2,
        ST_STORE      = 4'd3,
        ST_REPLAY     = 4'd4,
        ST_REPLAY_GAP = 4'd5,
        ST_DONE       = 4'd6,
        ST_ERR        = 4'd7
    } dflow_state_t;

    // States in which the watchdog counts down.
    function automatic logic is_watched(dflow_state_t s);
        return (s == ST_WAIT_CAL) || (s == ST_STORE) || (s == ST_REPLAY);
    endfunction

    // States that drive the soft reset to the engines.
    function automatic logic is_swrst_phase(dflow_state_t s);
        return (s == ST_SWRST) || (s == ST_ERR);
    endfunction

endpackage

// File: rtl/dflow_gen_sequencer_phase_timer.sv
// Loadable, clearable down-counter; tc is high while the count sits at zero.
module dflow_phase_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    // Clear beats load beats decrement; the count holds once it reaches zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/dflow_gen_sequencer.sv
// Sequencer for QDR store/replay: waits for calibration, soft-resets the
// engines, runs an optional store phase and a number of replay passes,
// guarded by a per-phase watchdog and an abort request.
//
// state      | meaning
// IDLE       | waiting for cmd_go
// WAIT_CAL   | waiting for init_calib_complete (watchdog active)
// SWRST      | sw_rst held for SW_RST_CYCLES
// STORE      | start_store held until compelete_store (watchdog active)
// REPLAY     | start_replay held until compelete_replay (watchdog active)
// REPLAY_GAP | one idle cycle so each pass gets a fresh start_replay edge
// DONE       | one-cycle done pulse
// ERR        | error set, sw_rst held for SW_RST_CYCLES, then back to IDLE
module dflow_gen_sequencer
    import dflow_gen_sequencer_pkg::*;
#(
    parameter int unsigned QDR_ADDR_WIDTH = DFLOW_QDR_ADDR_WIDTH,
    parameter int unsigned LOOP_WIDTH     = DFLOW_LOOP_WIDTH,
    parameter int unsigned TIMEOUT_WIDTH  = DFLOW_TIMEOUT_WIDTH,
    parameter int unsigned SW_RST_CYCLES  = DFLOW_SW_RST_CYCLES
) (
    input  logic                      qdr_clk,
    input  logic                      rst,
    input  logic                      cmd_go,
    input  logic                      cmd_abort,
    input  logic                      cfg_store_en,
    input  logic [LOOP_WIDTH-1:0]     cfg_loops,
    input  logic [TIMEOUT_WIDTH-1:0]  cfg_timeout,
    input  logic                      init_calib_complete,
    output logic                      sw_rst,
    output logic                      start_store,
    input  logic                      compelete_store,
    output logic                      start_replay,
    input  logic                      compelete_replay,
    input  logic [QDR_ADDR_WIDTH-1:0] mem_high_store,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [3:0]                state_dbg,
    output logic [LOOP_WIDTH-1:0]     loops_done,
    output logic [QDR_ADDR_WIDTH-1:0] mem_high_latched
);

    localparam int unsigned SW_W = (SW_RST_CYCLES > 1) ? $clog2(SW_RST_CYCLES) : 1;

    dflow_state_t state, state_next;

    logic                     store_en_q;
    logic [LOOP_WIDTH-1:0]    loops_q;
    logic [TIMEOUT_WIDTH-1:0] timeout_q;

    logic                     accept_go;
    logic                     entering;
    logic [LOOP_WIDTH-1:0]    eff_loops;
    logic [TIMEOUT_WIDTH-1:0] timeout_src;
    logic                     wd_tc, wd_expired;
    logic                     sw_tc;

    assign accept_go = (state == ST_IDLE) && cmd_go;
    assign entering  = (state_next != state);
    assign eff_loops = (loops_q == '0) ? LOOP_WIDTH'(1) : loops_q;

    // The watchdog is loaded on the same edge that latches the config, so
    // the first load has to come straight from the input.
    assign timeout_src = (state == ST_IDLE) ? cfg_timeout : timeout_q;
    assign wd_expired  = (timeout_q != '0) && wd_tc;

    dflow_phase_timer #(.WIDTH(SW_W)) u_sw_timer (
        .clk      (qdr_clk),
        .rst      (rst),
        .clr      (entering && !is_swrst_phase(state_next)),
        .load     (entering && is_swrst_phase(state_next)),
        .load_val (SW_W'(SW_RST_CYCLES - 1)),
        .en       (is_swrst_phase(state)),
        .tc       (sw_tc)
    );

    dflow_phase_timer #(.WIDTH(TIMEOUT_WIDTH)) u_wd_timer (
        .clk      (qdr_clk),
        .rst      (rst),
        .clr      (entering && !is_watched(state_next)),
        .load     (entering && is_watched(state_next)),
        .load_val (timeout_src - TIMEOUT_WIDTH'(1)),
        .en       (is_watched(state)),
        .tc       (wd_tc)
    );

    // Next-state decode; abort overrides everything outside IDLE and ERR.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:       if (cmd_go) state_next = ST_WAIT_CAL;
            ST_WAIT_CAL: begin
                if (init_calib_complete) state_next = ST_SWRST;
                else if (wd_expired)     state_next = ST_ERR;
            end
            ST_SWRST:      if (sw_tc) state_next = store_en_q ? ST_STORE : ST_REPLAY;
            ST_STORE: begin
                if (compelete_store)     state_next = ST_REPLAY;
                else if (wd_expired)     state_next = ST_ERR;
            end
            ST_REPLAY: begin
                if (compelete_replay)    state_next = ST_REPLAY_GAP;
                else if (wd_expired)     state_next = ST_ERR;
            end
            ST_REPLAY_GAP: state_next = (loops_done < eff_loops) ? ST_REPLAY : ST_DONE;
            ST_DONE:       state_next = ST_IDLE;
            ST_ERR:        if (sw_tc) state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
        if (cmd_abort && (state != ST_IDLE) && (state != ST_ERR)) begin
            state_next = ST_ERR;
        end
    end

    // State register and registered control outputs decoded from next state.
    always_ff @(posedge qdr_clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            sw_rst       <= 1'b0;
            start_store  <= 1'b0;
            start_replay <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_next;
            busy         <= (state_next != ST_IDLE);
            done         <= (state_next == ST_DONE);
            sw_rst       <= is_swrst_phase(state_next);
            start_store  <= (state_next == ST_STORE);
            start_replay <= (state_next == ST_REPLAY);
            if (accept_go) begin
                error <= 1'b0;
            end else if (state_next == ST_ERR) begin
                error <= 1'b1;
            end
        end
    end

    // Config capture, pass counter and store high-water capture.
    always_ff @(posedge qdr_clk) begin
        if (rst) begin
            store_en_q       <= 1'b0;
            loops_q          <= '0;
            timeout_q        <= '0;
            loops_done       <= '0;
            mem_high_latched <= '0;
        end else begin
            if (accept_go) begin
                store_en_q <= cfg_store_en;
                loops_q    <= cfg_loops;
                timeout_q  <= cfg_timeout;
                loops_done <= '0;
            end else if ((state == ST_REPLAY) && (state_next == ST_REPLAY_GAP)
                         && (loops_done != '1)) begin
                loops_done <= loops_done + LOOP_WIDTH'(1);
            end
            // Captured even when an abort lands in the same cycle.
            if ((state == ST_STORE) && compelete_store) begin
                mem_high_latched <= mem_high_store;
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_dflow_gen_sequencer.sv
// Directed bench for dflow_gen_sequencer with a result scoreboard.
module tb_dflow_gen_sequencer;

    logic        qdr_clk;
    logic        rst;
    logic        cmd_go, cmd_abort, cfg_store_en;
    logic [15:0] cfg_loops;
    logic [31:0] cfg_timeout;
    logic        init_calib_complete;
    logic        sw_rst, start_store, compelete_store, start_replay, compelete_replay;
    logic [18:0] mem_high_store, mem_high_latched;
    logic        busy, done, error;
    logic [3:0]  state_dbg;
    logic [15:0] loops_done;

    dflow_gen_sequencer dut (
        .qdr_clk             (qdr_clk),
        .rst                 (rst),
        .cmd_go              (cmd_go),
        .cmd_abort           (cmd_abort),
        .cfg_store_en        (cfg_store_en),
        .cfg_loops           (cfg_loops),
        .cfg_timeout         (cfg_timeout),
        .init_calib_complete (init_calib_complete),
        .sw_rst              (sw_rst),
        .start_store         (start_store),
        .compelete_store     (compelete_store),
        .start_replay        (start_replay),
        .compelete_replay    (compelete_replay),
        .mem_high_store      (mem_high_store),
        .busy                (busy),
        .done                (done),
        .error               (error),
        .state_dbg           (state_dbg),
        .loops_done          (loops_done),
        .mem_high_latched    (mem_high_latched)
    );

    initial qdr_clk = 1'b0;
    always #5 qdr_clk = ~qdr_clk;

    typedef struct {
        logic [15:0] loops;
        logic        err;
        logic [18:0] mem;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   sw_run, last_sw_run, replay_rises, store_seen, done_cnt;
    bit   prev_replay, prev_sw;
    logic [18:0] exp_mem;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [15:0] lp, input logic er, input logic [18:0] mem);
        exp_t e;
        e.loops = lp;
        e.err   = er;
        e.mem   = mem;
        return e;
    endfunction

    task automatic step();
        @(posedge qdr_clk);
        #1;
        if (start_replay && !prev_replay) replay_rises++;
        if (start_store) store_seen++;
        if (done) done_cnt++;
        if (sw_rst) sw_run++;
        else if (prev_sw) begin
            last_sw_run = sw_run;
            sw_run = 0;
        end
        prev_replay = start_replay;
        prev_sw     = sw_rst;
    endtask

    task automatic clr_stats();
        sw_run = 0; last_sw_run = 0; replay_rises = 0; store_seen = 0; done_cnt = 0;
    endtask

    task automatic issue_go(input bit se, input logic [15:0] lp, input logic [31:0] to,
                            input exp_t e);
        cfg_store_en = se;
        cfg_loops    = lp;
        cfg_timeout  = to;
        cmd_go       = 1'b1;
        if (!busy) sb.push_back(e);
        step();
        cmd_go = 1'b0;
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_loops"}, 32'(loops_done), 32'(e.loops));
            chk({tag, "_error"}, 32'(error), 32'(e.err));
            chk({tag, "_mem_high"}, 32'(mem_high_latched), 32'(e.mem));
        end
    endtask

    // Acts as the store/replay engines until the sequencer drops busy.
    task automatic run_engines(input string tag, input int st_lat, input int rp_lat,
                               input int budget);
        int st_cnt = 0;
        int rp_cnt = 0;
        bit fin = 1'b0;
        for (int i = 0; i < budget && !fin; i++) begin
            compelete_store  = 1'b0;
            compelete_replay = 1'b0;
            if (start_store) begin
                st_cnt++;
                if (st_cnt >= st_lat) begin compelete_store = 1'b1; st_cnt = 0; end
            end
            if (start_replay) begin
                rp_cnt++;
                if (rp_cnt >= rp_lat) begin compelete_replay = 1'b1; rp_cnt = 0; end
            end
            step();
            if (!busy) fin = 1'b1;
        end
        compelete_store  = 1'b0;
        compelete_replay = 1'b0;
        chk({tag, "_finished"}, 32'(fin), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_sw_rst"}, 32'(sw_rst), 32'd0);
        chk({tag, "_start_store"}, 32'(start_store), 32'd0);
        chk({tag, "_start_replay"}, 32'(start_replay), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_loops_done"}, 32'(loops_done), 32'd0);
        chk({tag, "_mem_high"}, 32'(mem_high_latched), 32'd0);
        chk({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; cmd_go = 1'b0; cmd_abort = 1'b0; cfg_store_en = 1'b0;
        cfg_loops = '0; cfg_timeout = '0; init_calib_complete = 1'b0;
        compelete_store = 1'b0; compelete_replay = 1'b0; mem_high_store = '0;
        prev_replay = 1'b0; prev_sw = 1'b0; exp_mem = '0;
        clr_stats();
        step(); step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // Store + two replay passes.
        clr_stats();
        init_calib_complete = 1'b1;
        mem_high_store = 19'h1234;
        exp_mem = 19'h1234;
        issue_go(1'b1, 16'd2, 32'd0, mk_exp(16'd2, 1'b0, exp_mem));
        chk("s1_wait_cal", 32'(state_dbg), 32'd1);
        run_engines("s1", 5, 4, 300);
        chk("s1_sw_rst_len", 32'(last_sw_run), 32'd16);
        chk("s1_store_cycles", 32'(store_seen), 32'd5);
        chk("s1_replay_edges", 32'(replay_rises), 32'd2);
        chk("s1_done_pulses", 32'(done_cnt), 32'd1);
        sb_check("s1");

        // Replay only, loops=0 behaves as one pass; latched address untouched.
        clr_stats();
        mem_high_store = 19'h5555;
        issue_go(1'b0, 16'd0, 32'd0, mk_exp(16'd1, 1'b0, exp_mem));
        run_engines("s2", 3, 6, 300);
        chk("s2_store_cycles", 32'(store_seen), 32'd0);
        chk("s2_replay_edges", 32'(replay_rises), 32'd1);
        chk("s2_done_pulses", 32'(done_cnt), 32'd1);
        sb_check("s2");

        // Calibration never arrives: watchdog expiry after 100 cycles.
        clr_stats();
        init_calib_complete = 1'b0;
        issue_go(1'b1, 16'd1, 32'd100, mk_exp(16'd0, 1'b1, exp_mem));
        n = 0;
        while (state_dbg == 4'd1 && n < 300) begin step(); n++; end
        chk("s3_wait_cal_cycles", 32'(n), 32'd100);
        chk("s3_err_state", 32'(state_dbg), 32'd7);
        chk("s3_error", 32'(error), 32'd1);
        run_engines("s3", 2, 2, 100);
        chk("s3_sw_rst_len", 32'(last_sw_run), 32'd16);
        chk("s3_idle", 32'(state_dbg), 32'd0);
        sb_check("s3");

        // Abort in the third REPLAY cycle, then a new go clears error.
        clr_stats();
        init_calib_complete = 1'b1;
        issue_go(1'b0, 16'd3, 32'd0, mk_exp(16'd0, 1'b1, exp_mem));
        n = 0;
        while (!start_replay && n < 100) begin step(); n++; end
        chk("s4_replay_seen", 32'(start_replay), 32'd1);
        step(); step();
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
        chk("s4_replay_dropped", 32'(start_replay), 32'd0);
        chk("s4_error", 32'(error), 32'd1);
        chk("s4_err_state", 32'(state_dbg), 32'd7);
        run_engines("s4", 2, 2, 100);
        sb_check("s4");
        issue_go(1'b0, 16'd1, 32'd0, mk_exp(16'd1, 1'b0, exp_mem));
        chk("s4_error_cleared", 32'(error), 32'd0);
        run_engines("s4b", 2, 3, 200);
        sb_check("s4b");

        // Store completion and abort together: abort wins, address still captured.
        clr_stats();
        mem_high_store = 19'h0ABC;
        exp_mem = 19'h0ABC;
        issue_go(1'b1, 16'd1, 32'd0, mk_exp(16'd0, 1'b1, exp_mem));
        n = 0;
        while (!start_store && n < 100) begin step(); n++; end
        chk("s5_store_seen", 32'(start_store), 32'd1);
        compelete_store = 1'b1;
        cmd_abort = 1'b1;
        step();
        compelete_store = 1'b0;
        cmd_abort = 1'b0;
        chk("s5_err_state", 32'(state_dbg), 32'd7);
        chk("s5_store_dropped", 32'(start_store), 32'd0);
        chk("s5_no_replay", 32'(start_replay), 32'd0);
        chk("s5_mem_high", 32'(mem_high_latched), 32'h0ABC);
        run_engines("s5", 50, 50, 100);
        sb_check("s5");

        // Reset in STORE; go while busy is ignored.
        clr_stats();
        issue_go(1'b1, 16'd2, 32'd0, mk_exp(16'd2, 1'b0, exp_mem));
        n = 0;
        while (!start_store && n < 100) begin step(); n++; end
        chk("s6_store_seen", 32'(start_store), 32'd1);
        issue_go(1'b0, 16'd5, 32'd0, mk_exp(16'd5, 1'b0, exp_mem));
        chk("s6_go_ignored_state", 32'(state_dbg), 32'd3);
        chk("s6_go_ignored_store", 32'(start_store), 32'd1);
        chk("s6_sb_one_entry", 32'(sb.size()), 32'd1);
        rst = 1'b1;
        step();
        check_all_zero("s6_rst");
        rst = 1'b0;
        sb.delete();
        step();
        chk("s6_no_sw_rst", 32'(sw_rst), 32'd0);
        chk("s6_idle", 32'(state_dbg), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
